// File: rtl/mpi_eth_pkg.sv
// Shared MPI-over-Ethernet definitions: descriptor layout and header word map.
// Used by the header inserter, the downstream parser and bin_stream.
package mpi_eth_pkg;

    localparam int HDR_WORDS = 4;
    localparam int DATA_W    = 64;
    localparam int KEEP_W    = 8;
    localparam int MAC_W     = 48;
    localparam int IP_W      = 32;
    localparam int DRANK_W   = 16;
    localparam int SRANK_W   = 8;
    localparam int TYPE_W    = 8;
    localparam int TAG_W     = 8;
    localparam int SIZE_W    = 32;

    localparam logic [TYPE_W-1:0] PT_EAGER      = 8'h00;
    localparam logic [TYPE_W-1:0] PT_RNDZV_INIT = 8'h01;
    localparam logic [TYPE_W-1:0] PT_RNDZV_DATA = 8'h02;
    localparam logic [TYPE_W-1:0] PT_BARRIER    = 8'h03;

    typedef struct packed {
        logic [MAC_W-1:0]   mac_dst;
        logic [MAC_W-1:0]   mac_src;
        logic [IP_W-1:0]    ip_dst;
        logic [IP_W-1:0]    ip_src;
        logic [DRANK_W-1:0] dst_rank;
        logic [SRANK_W-1:0] src_rank;
        logic [TYPE_W-1:0]  packet_type;
        logic [TAG_W-1:0]   tag;
        logic [SIZE_W-1:0]  size;
        logic               last;
    } mpi_hdr_t;

    function automatic logic [DATA_W-1:0] hdr_word(input mpi_hdr_t h,
                                                   input logic [1:0] idx);
        logic [DATA_W-1:0] w;
        case (idx)
            2'd0:    w = {h.mac_dst, h.mac_src[47:32]};
            2'd1:    w = {h.mac_src[31:0], h.ip_src};
            2'd2:    w = {h.ip_dst, h.dst_rank, h.src_rank, h.packet_type};
            default: w = {h.size, h.tag, 24'h0};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry stream output register; contents hold while the sink stalls.
// Loads whenever the slot is empty or being drained this cycle.
module axis_out_reg
    import mpi_eth_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    output logic              in_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last,
    input  logic              m_ready
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              last_q, last_d;

    assign in_ready = !valid_q || m_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
                keep_d = in_keep;
                last_d = in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_keep  = keep_q;
    assign m_last  = last_q;

endmodule

// File: rtl/mpi_eth_hdr_insert.sv
// Prepends four MPI/Ethernet header words to a 64-bit payload stream.
// One descriptor per packet; output is a single register stage.
module mpi_eth_hdr_insert
    import mpi_eth_pkg::*;
#(
    parameter int PKT_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hdr_valid,
    output logic                 hdr_ready,
    input  logic [MAC_W-1:0]     mac_dst,
    input  logic [MAC_W-1:0]     mac_src,
    input  logic [IP_W-1:0]      ip_dst,
    input  logic [IP_W-1:0]      ip_src,
    input  logic [DRANK_W-1:0]   dst_rank,
    input  logic [SRANK_W-1:0]   src_rank,
    input  logic [TYPE_W-1:0]    packet_type,
    input  logic [TAG_W-1:0]     tag,
    input  logic [SIZE_W-1:0]    size,
    input  logic                 hdr_last,
    input  logic [DATA_W-1:0]    s_data,
    input  logic [KEEP_W-1:0]    s_keep,
    input  logic                 s_last,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic [KEEP_W-1:0]    m_keep,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PKT_CNT_W-1:0] pkt_count
);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t               state_q, state_d;
    mpi_hdr_t             hdr_q, hdr_d;
    logic [1:0]           hcnt_q, hcnt_d;
    logic [PKT_CNT_W-1:0] pkt_q, pkt_d;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [KEEP_W-1:0] out_keep;
    logic              out_last;
    logic              out_ready;

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        hcnt_d    = hcnt_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_keep  = '0;
        out_last  = 1'b0;
        s_ready   = 1'b0;
        hdr_ready = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (hdr_valid) begin
                    hdr_d.mac_dst     = mac_dst;
                    hdr_d.mac_src     = mac_src;
                    hdr_d.ip_dst      = ip_dst;
                    hdr_d.ip_src      = ip_src;
                    hdr_d.dst_rank    = dst_rank;
                    hdr_d.src_rank    = src_rank;
                    hdr_d.packet_type = packet_type;
                    hdr_d.tag         = tag;
                    hdr_d.size        = size;
                    hdr_d.last        = hdr_last;
                    hcnt_d            = 2'd0;
                    state_d           = HDR;
                end
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_word(hdr_q, hcnt_q);
                out_keep  = '1;
                out_last  = (hcnt_q == 2'd3) && hdr_q.last;
                if (out_ready) begin
                    hcnt_d = hcnt_q + 2'd1;
                    if (hcnt_q == 2'd3) begin
                        state_d = hdr_q.last ? IDLE : PAY;
                    end
                end
            end
            PAY: begin
                s_ready   = out_ready;
                out_valid = s_valid;
                out_data  = s_data;
                out_keep  = s_keep;
                out_last  = s_last;
                if (s_valid && out_ready && s_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pkt_d = pkt_q;
        if (m_valid && m_ready && m_last) begin
            pkt_d = pkt_q + {{(PKT_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            hcnt_q  <= 2'd0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            hcnt_q  <= hcnt_d;
            pkt_q   <= pkt_d;
        end
    end

    assign pkt_count = pkt_q;

    axis_out_reg u_out (
        .clk      (clk),
        .reset    (reset),
        .in_valid (out_valid),
        .in_data  (out_data),
        .in_keep  (out_keep),
        .in_last  (out_last),
        .in_ready (out_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_keep   (m_keep),
        .m_last   (m_last),
        .m_ready  (m_ready)
    );

endmodule

// File: tb/tb_mpi_eth_hdr_insert.sv
// Scoreboard bench for mpi_eth_hdr_insert: driver pushes expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_mpi_eth_hdr_insert;

    logic        clk = 1'b0;
    logic        reset;
    logic        hdr_valid, hdr_ready;
    logic [47:0] mac_dst, mac_src;
    logic [31:0] ip_dst, ip_src;
    logic [15:0] dst_rank;
    logic [7:0]  src_rank, packet_type, tag;
    logic [31:0] size;
    logic        hdr_last;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_last, s_valid, s_ready;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_last, m_valid, m_ready;
    logic [3:0]  pkt_count;

    always #5 clk = ~clk;

    mpi_eth_hdr_insert #(.PKT_CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .mac_dst(mac_dst), .mac_src(mac_src),
        .ip_dst(ip_dst), .ip_src(ip_src),
        .dst_rank(dst_rank), .src_rank(src_rank),
        .packet_type(packet_type), .tag(tag), .size(size),
        .hdr_last(hdr_last),
        .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .pkt_count(pkt_count)
    );

    // Words stored as {last, keep, data}
    logic [72:0] exp_q[$];
    logic [72:0] got_q[$];
    logic [72:0] ref_q[$];
    int tests = 0;
    int fails = 0;
    int nwords = 0;
    bit rnd = 1'b0;
    bit chk_sready = 1'b0;

    task automatic chk(input string name, input logic [72:0] act,
                       input logic [72:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic [72:0] prev_w;
    bit stall = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (stall) chk("stall_hold", {m_last, m_keep, m_data}, prev_w);
            if (chk_sready) chk("s_ready_low", 73'(s_ready), 73'd0);
            if (m_valid && m_ready) begin
                got_q.push_back({m_last, m_keep, m_data});
                nwords++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h expected none",
                             {m_last, m_keep, m_data});
                end else begin
                    chk("sb_word", {m_last, m_keep, m_data}, exp_q.pop_front());
                end
            end
            stall = m_valid && !m_ready;
            prev_w = {m_last, m_keep, m_data};
        end
    end

    task automatic set_hdr(input logic [47:0] md, input logic [47:0] ms,
                           input logic [31:0] is, input logic [31:0] id,
                           input logic [15:0] dr, input logic [7:0] sr,
                           input logic [7:0] pt, input logic [7:0] tg,
                           input logic [31:0] sz);
        mac_dst = md; mac_src = ms; ip_src = is; ip_dst = id;
        dst_rank = dr; src_rank = sr; packet_type = pt; tag = tg; size = sz;
    endtask

    task automatic push_exp(input int nb, input logic [63:0] base);
        exp_q.push_back({1'b0, 8'hFF, mac_dst, mac_src[47:32]});
        exp_q.push_back({1'b0, 8'hFF, mac_src[31:0], ip_src});
        exp_q.push_back({1'b0, 8'hFF, ip_dst, dst_rank, src_rank, packet_type});
        exp_q.push_back({nb == 0, 8'hFF, size, tag, 24'h0});
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back({i == nb - 1, (i == nb - 1) ? 8'h0F : 8'hFF,
                             base + 64'(i)});
        end
    endtask

    task automatic hs_hdr();
        int t = 0;
        hdr_valid = 1'b1;
        @(negedge clk);
        while (!hdr_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("hdr_timeout", 73'd1, 73'd0);
        @(posedge clk);
        #1;
        hdr_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic l);
        int t = 0;
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
        @(negedge clk);
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("beat_timeout", 73'd1, 73'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_pkt(input int nb, input logic [63:0] base);
        hdr_last = (nb == 0);
        push_exp(nb, base);
        hs_hdr();
        for (int i = 0; i < nb; i++) begin
            send_beat(base + 64'(i), (i == nb - 1) ? 8'h0F : 8'hFF, i == nb - 1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("drain_left", 73'(exp_q.size()), 73'd0);
    endtask

    task automatic do_reset();
        hdr_valid = 1'b0;
        s_valid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic basic_hdr();
        set_hdr(48'h0A0B0C0D0E0F, 48'h112233445566, 32'hC0A80001,
                32'hC0A80002, 16'h0003, 8'h01, 8'h02, 8'h05, 32'd16);
    endtask

    initial begin
        reset = 1'b1;
        hdr_valid = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0;
        s_last = 1'b0; hdr_last = 1'b0; m_ready = 1'b1;
        set_hdr('0, '0, '0, '0, '0, '0, '0, '0, '0);
        #3;
        chk("rst_m_valid", 73'(m_valid), 73'd0);
        chk("rst_m_data", 73'(m_data), 73'd0);
        chk("rst_m_keep", 73'(m_keep), 73'd0);
        chk("rst_m_last", 73'(m_last), 73'd0);
        chk("rst_s_ready", 73'(s_ready), 73'd0);
        chk("rst_hdr_ready", 73'(hdr_ready), 73'd1);
        chk("rst_pkt_count", 73'(pkt_count), 73'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic two-beat packet
        got_q.delete(); nwords = 0;
        basic_hdr();
        send_pkt(2, 64'hDEAD_BEEF_0000_0000);
        drain();
        chk("basic_words", 73'(nwords), 73'd6);
        if (got_q.size() >= 6) begin
            chk("basic_w0", 73'(got_q[0][63:0]), 73'(64'h0A0B0C0D0E0F1122));
            chk("basic_w1", 73'(got_q[1][63:0]), 73'(64'h33445566C0A80001));
            chk("basic_w2", 73'(got_q[2][63:0]), 73'(64'hC0A8000200030102));
            chk("basic_w3", 73'(got_q[3][63:0]), 73'(64'h0000001005000000));
            chk("basic_w3_last", 73'(got_q[3][72]), 73'd0);
            chk("basic_p0_last", 73'(got_q[4][72]), 73'd0);
            chk("basic_p1_last", 73'(got_q[5][72]), 73'd1);
        end
        chk("basic_pkt_count", 73'(pkt_count), 73'd1);
        ref_q = got_q;

        // Header-only packet
        do_reset();
        nwords = 0;
        chk_sready = 1'b1;
        set_hdr(48'hFFEEDDCCBBAA, 48'h010203040506, 32'h0A000001,
                32'h0A000002, 16'h1234, 8'h7F, 8'h03, 8'hA5, 32'd0);
        send_pkt(0, '0);
        drain();
        chk_sready = 1'b0;
        chk("hdronly_words", 73'(nwords), 73'd4);
        chk("hdronly_pkt_count", 73'(pkt_count), 73'd1);

        // Backpressure replay of the basic packet
        do_reset();
        got_q.delete();
        rnd = 1'b1;
        basic_hdr();
        send_pkt(2, 64'hDEAD_BEEF_0000_0000);
        drain();
        rnd = 1'b0;
        chk("bp_len", 73'(got_q.size()), 73'(ref_q.size()));
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
            chk("bp_word", got_q[i], ref_q[i]);
        end
        repeat (2) @(negedge clk);
        chk("bp_pkt_count", 73'(pkt_count), 73'd1);

        // Back-to-back frames
        do_reset();
        nwords = 0;
        basic_hdr();
        send_pkt(1, 64'h1111_0000_0000_0001);
        set_hdr(48'h00000000AAAA, 48'h00000000BBBB, 32'h1, 32'h2,
                16'h0010, 8'h02, 8'h00, 8'h11, 32'd8);
        send_pkt(1, 64'h2222_0000_0000_0002);
        set_hdr(48'h123456789ABC, 48'hCBA987654321, 32'h3, 32'h4,
                16'h0020, 8'h03, 8'h01, 8'h22, 32'd4);
        send_pkt(1, 64'h3333_0000_0000_0003);
        drain();
        chk("b2b_words", 73'(nwords), 73'd15);
        chk("b2b_pkt_count", 73'(pkt_count), 73'd3);

        // Reset during the second payload beat
        do_reset();
        basic_hdr();
        hdr_last = 1'b0;
        push_exp(3, 64'h5555_0000_0000_0000);
        hs_hdr();
        send_beat(64'h5555_0000_0000_0000, 8'hFF, 1'b0);
        s_valid = 1'b1; s_data = 64'h5555_0000_0000_0001;
        s_keep = 8'hFF; s_last = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_mid_m_valid", 73'(m_valid), 73'd0);
        chk("rst_mid_pkt_count", 73'(pkt_count), 73'd0);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        got_q.delete(); nwords = 0;
        set_hdr(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 32'h0B0B0B0B,
                32'h0C0C0C0C, 16'h0007, 8'h09, 8'h01, 8'h33, 32'd8);
        send_pkt(1, 64'h6666_0000_0000_0000);
        drain();
        chk("after_rst_words", 73'(nwords), 73'd5);
        if (got_q.size() >= 1) begin
            chk("after_rst_w0", 73'(got_q[0][63:0]), 73'(64'hA1A2A3A4A5A6B1B2));
        end
        chk("after_rst_pkt_count", 73'(pkt_count), 73'd1);

        // Counter wrap with a 4-bit counter
        do_reset();
        basic_hdr();
        for (int p = 0; p < 17; p++) send_pkt(0, '0);
        drain();
        chk("wrap_pkt_count", 73'(pkt_count), 73'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mpi_eth_hdr_insert.md
# mpi_eth_hdr_insert

Builds MPI-over-Ethernet frames for the 64-bit stream path. It accepts one latched header descriptor per packet and an AXI-style payload stream, then emits four fixed header words followed by the payload, one word per cycle. It sits directly upstream of the `stream_in_*` DUT port that `bin_stream` stimulus currently drives in simulation, and it replaces hand-built header words in hardware.

## Interface
Parameters:
- `PKT_CNT_W`, default 32: width of the sent-packet counter.

Ports:
- `clk`  in  1  single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `hdr_valid`  in  1  header descriptor valid.
- `hdr_ready`  out  1  descriptor accepted when `hdr_valid & hdr_ready`.
- `mac_dst`, `mac_src`  in  48 each  Ethernet addresses.
- `ip_dst`, `ip_src`  in  32 each  IP addresses.
- `dst_rank`  in  16  destination rank.
- `src_rank`  in  8  source rank.
- `packet_type`  in  8  MPI packet type.
- `tag`  in  8  MPI tag.
- `size`  in  32  payload byte count; carried in the header only, never checked.
- `hdr_last`  in  1  1 = header-only packet, no payload follows.
- `s_data`  in  64, `s_keep`  in  8, `s_last`  in  1, `s_valid`  in  1  payload input.
- `s_ready`  out  1  payload ready.
- `m_data`  out  64, `m_keep`  out  8, `m_last`  out  1, `m_valid`  out  1  frame output.
- `m_ready`  in  1  frame ready.
- `pkt_count`  out  `PKT_CNT_W`  frames completed.

## Operation
- FSM states: `IDLE`, `HDR`, `PAY`.
- **IDLE**
  - `hdr_ready=1`.
  - On handshake: latch all fields, set `hcnt=0`, go to `HDR`.
- **HDR**
  - Emits words W0..W3 as output-register space allows; `hcnt` increments per emitted word.
  - W0 = `{mac_dst, mac_src[47:32]}`.
  - W1 = `{mac_src[31:0], ip_src}`.
  - W2 = `{ip_dst, dst_rank, src_rank, packet_type}`.
  - W3 = `{size, tag, 24'h0}`.
  - `m_keep=8'hFF` on all header words.
  - After W3: go to `PAY` if latched `hdr_last=0`. Otherwise W3 carries `m_last=1` and the FSM goes to `IDLE`.
- **PAY**
  - `s_ready = (!m_valid | m_ready)`.
  - Each accepted beat copies `s_data`, `s_keep`, `s_last` to the output register unchanged.
  - Accepting a beat with `s_last=1` returns the FSM to `IDLE`.
- `s_ready=0` in `IDLE` and `HDR`. `hdr_ready=0` in `HDR` and `PAY`.
- `pkt_count` increments when a word with `m_last=1` handshakes on the output; it wraps modulo 2^`PKT_CNT_W`.
- Payload `s_keep` is not validated; zero-keep beats pass through.

## Timing
- Reset values: `m_valid=0`, `m_data=0`, `m_keep=0`, `m_last=0`, `s_ready=0`, `hdr_ready=1`, `pkt_count=0`, state=`IDLE`.
- Reset mid-frame aborts the frame immediately: `m_valid` drops asynchronously and no partial tail is emitted afterwards.
- Output is a single register stage. It loads when `!m_valid | m_ready`. While `m_valid=1 & m_ready=0`, all `m_*` outputs hold stable.
- Latency:
  - Descriptor handshake at cycle N → W0 valid at N+1.
  - W0..W3 at N+1..N+4 with `m_ready` held high.
  - First payload beat accepted at N+4, appears at N+5.
- Throughput is 1 word/cycle with no bubbles between header and payload, or between payload beats, while `m_ready=1`.
- Back-to-back packets:
  - `hdr_ready` rises in the cycle after the last input beat is accepted.
  - Minimum gap is one idle cycle on the output between frames.
- A descriptor handshake is never accepted in the same cycle as a payload beat.

## Structure
- Shared package `mpi_eth_pkg` holds:
  - `HDR_WORDS=4`;
  - field width constants;
  - packet type constants;
  - a `mpi_hdr_t` packed struct for the descriptor;
  - function `hdr_word(mpi_hdr_t, idx)` returning W0..W3.
- The same package is reused by the downstream parser and by `bin_stream`.
- One sub-module: `axis_out_reg`, a single-entry output register with valid/ready hold semantics.

## Test plan
- **Basic packet:** descriptor with `mac_dst=48'h0A0B0C0D0E0F`, `mac_src=48'h112233445566`, `ip_src=32'hC0A80001`, `ip_dst=32'hC0A80002`, `dst_rank=16'h0003`, `src_rank=8'h01`, `packet_type=8'h02`, `size=32'd16`, `tag=8'h05`; two payload beats → W0=`64'h0A0B0C0D0E0F1122`, W3=`64'h0000001005000000`, payload follows, `m_last` only on the second payload beat, `pkt_count=1`.
- **Header-only packet:** `hdr_last=1` → exactly 4 output words, W3 has `m_last=1`, `s_ready` stays 0 throughout.
- **Backpressure:** `m_ready` toggling at random 50% → output data stream bit-identical to the `m_ready=1` run, and `m_*` stable on every stalled cycle.
- **Back-to-back frames:** 3 descriptors pre-queued with 1-beat payloads → 15 output words, no lost or duplicated beats, `pkt_count=3`.
- **Reset mid-payload:** `reset` asserted during the second payload beat → `m_valid=0` immediately, `pkt_count=0`; the next packet after release is emitted correctly starting from W0.
- **Counter wrap:** `PKT_CNT_W=4`, 17 packets → `pkt_count=1`.
